mos_core_regs: RTL and testbench
================================

# mos_core_regs

Programmer-visible register set of the MOSby 6502-style core, with its own two-phase clock generator: X, Y, accumulator (A), stack pointer (SP) and processor status (P), each 8 bits. A single master clock drives internal non-overlapping phase strobes. Registers commit only in phase 2. The block sits between the datapath/ALU (data sources) and the control decoder (load strobes).

## Interface
- Parameters: none.
- clk  in  1  master clock; every flop is clocked on its rising edge.
- rst  in  1  reset, synchronous and active-low (sampled on rising clk).
- x_con  in  1  load X from data_in.
- y_con  in  1  load Y from data_in.
- accumulator_con  in  1  load A from data_in.
- stack_pointer_con  in  1  load SP from data_in.
- status_con  in  1  load P from data_status.
- data_in  in  8  shared write data for X, Y, A, SP.
- data_status  in  8  write data for P.
- sp_inc, sp_dec  in  1 each  SP step requests (present only with MOS_REGS_SP_STEP_EN).
- data_out_x, data_out_y, data_out_accumulator, data_out_sp, data_out_status  out  8 each  current register contents, driven directly from flops.
- phi1, phi2  out  1 each  phase strobes, complementary and registered.

## Operation
- Phase generator: a one-bit phase flop.
  - Reset forces phase 1: phi1=1, phi2=0.
  - Out of reset, the flop toggles on every rising clk, so the phases alternate 1,2,1,2…
  - phi1 = ~phi2 at all times; the two are never high together.
- Register writes are accepted only on a rising clk edge where phi2=1 and rst=1. Load strobes presented during phi1 are ignored.
- Each con strobe is independent. Any combination may be asserted at once, and all selected registers load in the same edge (X/Y/A/SP from data_in, P from data_status).
- P bit 5 is unimplemented and always reads 1, whatever is written.
- Reset values (after rising clk with rst=0):
  - X = 0x00, Y = 0x00, A = 0x00
  - SP = 0xFF
  - P = 0x24 (I=1, bit5=1)
  - phi1 = 1, phi2 = 0
- Reset wins over every load and step, including a reset arriving mid-phase-2.

## Timing
- Write latency: data is sampled at the phi2 rising clk edge and appears on data_out_* immediately after that edge. No combinational path from inputs to outputs.
- After rst deasserts, the first edge toggles to phi2 and the second edge is the first write edge.
- Write opportunity: one per two clk cycles.
- Outputs are stable for the full two-cycle phase pair between writes.

## Configuration
- MOS_REGS_SP_STEP_EN defined: adds sp_inc and sp_dec, evaluated at phi2 write edges only.
  - stack_pointer_con has priority over both.
  - sp_inc alone: SP+1. sp_dec alone: SP−1.
  - sp_inc and sp_dec together: SP unchanged.
  - Wrap: 0xFF+1 gives 0x00; 0x00−1 gives 0xFF.
- MOS_REGS_SP_STEP_EN undefined: ports absent; SP changes only by load or reset.

## Test plan
- Reset: hold rst=0 for 2 clk → X=Y=A=0x00, SP=0xFF, P=0x24, phi1=1, phi2=0; release → phi2=1 after the next edge, then alternates each clk.
- Phase-gated load: data_in=0x5A with x_con=1 held only during phi1 → X stays 0x00; held across the phi2 edge → X=0x5A right after that edge.
- Simultaneous loads: all five cons=1, data_in=0xC3, data_status=0x81 on a phi2 edge → X=Y=A=SP=0xC3, P=0xA1.
- P bit 5: load data_status=0x00 → P reads 0x20.
- Mid-operation reset: load A=0x7F, then rst=0 on a phi2 edge with accumulator_con=1, data_in=0x11 → A=0x00, SP=0xFF, phases restart at phi1.
- SP stepping (MOS_REGS_SP_STEP_EN defined):
  - SP=0xFF, sp_inc → 0x00.
  - SP=0x00, sp_dec → 0xFF.
  - sp_inc+sp_dec → unchanged.
  - stack_pointer_con=1, data_in=0x40 with sp_dec=1 → 0x40.

Source files
------------

// File: rtl/mos_core_regs_if.sv
// mos_core_regs_if: bus between the control decoder / datapath and the
// MOSby register set. The sp_inc/sp_dec step requests exist only when
// MOS_REGS_SP_STEP_EN is defined.
interface mos_core_regs_if;
  logic       x_con;
  logic       y_con;
  logic       accumulator_con;
  logic       stack_pointer_con;
  logic       status_con;
  logic [7:0] data_in;
  logic [7:0] data_status;
`ifdef MOS_REGS_SP_STEP_EN
  logic       sp_inc;
  logic       sp_dec;
`endif
  logic [7:0] data_out_x;
  logic [7:0] data_out_y;
  logic [7:0] data_out_accumulator;
  logic [7:0] data_out_sp;
  logic [7:0] data_out_status;
  logic       phi1;
  logic       phi2;

  // Decoder/datapath side: drives strobes and data, observes registers.
  modport master (
    output x_con, y_con, accumulator_con, stack_pointer_con, status_con,
    output data_in, data_status,
`ifdef MOS_REGS_SP_STEP_EN
    output sp_inc, sp_dec,
`endif
    input  data_out_x, data_out_y, data_out_accumulator, data_out_sp,
    input  data_out_status, phi1, phi2
  );

  // Register-file side.
  modport slave (
    input  x_con, y_con, accumulator_con, stack_pointer_con, status_con,
    input  data_in, data_status,
`ifdef MOS_REGS_SP_STEP_EN
    input  sp_inc, sp_dec,
`endif
    output data_out_x, data_out_y, data_out_accumulator, data_out_sp,
    output data_out_status, phi1, phi2
  );
endinterface

// File: rtl/mos_core_regs.sv
// mos_core_regs: X/Y/A/SP/P register set of the MOSby core with its own
// two-phase strobe generator. Registers commit only on phase-2 edges.
// Optional feature macro: MOS_REGS_SP_STEP_EN (adds SP increment/decrement).
module mos_core_regs (
  input  logic            clk,
  input  logic            rst,
  mos_core_regs_if.slave  bus
);

  localparam logic [7:0] SP_RST = 8'hFF;
  localparam logic [7:0] P_RST  = 8'h24;
  localparam logic [7:0] P_B5   = 8'h20;

  logic       r_phi1;
  logic       r_phi2;
  logic [7:0] r_x;
  logic [7:0] r_y;
  logic [7:0] r_a;
  logic [7:0] r_sp;
  logic [7:0] r_p;
  logic       w_wr;

  // The edge ending a phi2 cycle is the only write opportunity.
  assign w_wr = r_phi2;

  // Phase generator: both strobes are flops so they never overlap or glitch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phi1 <= 1'b1;
      r_phi2 <= 1'b0;
    end else begin
      r_phi1 <= r_phi2;
      r_phi2 <= r_phi1;
    end
  end

  // X, Y, A loads from the shared data bus.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x <= 8'h00;
      r_y <= 8'h00;
      r_a <= 8'h00;
    end else if (w_wr) begin
      if (bus.x_con)           r_x <= bus.data_in;
      if (bus.y_con)           r_y <= bus.data_in;
      if (bus.accumulator_con) r_a <= bus.data_in;
    end
  end

  // Status register; bit 5 is not stored state and always reads 1.
  always_ff @(posedge clk) begin
    if (!rst)                       r_p <= P_RST;
    else if (w_wr && bus.status_con) r_p <= bus.data_status | P_B5;
  end

`ifdef MOS_REGS_SP_STEP_EN
  // Stack pointer: load beats stepping; inc and dec together cancel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sp <= SP_RST;
    end else if (w_wr) begin
      if (bus.stack_pointer_con)        r_sp <= bus.data_in;
      else if (bus.sp_inc && !bus.sp_dec) r_sp <= r_sp + 8'd1;
      else if (bus.sp_dec && !bus.sp_inc) r_sp <= r_sp - 8'd1;
    end
  end
`else
  // Stack pointer: changes only by load or reset.
  always_ff @(posedge clk) begin
    if (!rst)                              r_sp <= SP_RST;
    else if (w_wr && bus.stack_pointer_con) r_sp <= bus.data_in;
  end
`endif

  assign bus.data_out_x           = r_x;
  assign bus.data_out_y           = r_y;
  assign bus.data_out_accumulator = r_a;
  assign bus.data_out_sp          = r_sp;
  assign bus.data_out_status      = r_p;
  assign bus.phi1                 = r_phi1;
  assign bus.phi2                 = r_phi2;

endmodule

// File: tb/tb_mos_core_regs.sv
// tb_mos_core_regs: directed scoreboard bench for mos_core_regs. Stimulus
// pushes hand-computed register snapshots; a monitor on the falling edge
// pops and compares them against the DUT outputs.
module tb_mos_core_regs;

  typedef struct {
    string      tag;
    logic [41:0] exp;  // {x, y, a, sp, p, phi1, phi2}
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;
  item_t q[$];

  mos_core_regs_if bus ();

  mos_core_regs dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are settled by the falling edge; compare every snapshot.
  always @(negedge clk) begin
    logic [41:0] act;
    item_t       it;
    while (q.size() > 0) begin
      it  = q.pop_front();
      act = {bus.data_out_x, bus.data_out_y, bus.data_out_accumulator,
             bus.data_out_sp, bus.data_out_status, bus.phi1, bus.phi2};
      n_chk++;
      if (act !== it.exp) begin
        n_err++;
        $display("FAIL %s: got x=%h y=%h a=%h sp=%h p=%h phi1=%b phi2=%b, want x=%h y=%h a=%h sp=%h p=%h phi1=%b phi2=%b",
                 it.tag, act[41:34], act[33:26], act[25:18], act[17:10], act[9:2], act[1], act[0],
                 it.exp[41:34], it.exp[33:26], it.exp[25:18], it.exp[17:10], it.exp[9:2],
                 it.exp[1], it.exp[0]);
      end
    end
  end

  // One clock edge, then queue the expected state right after it.
  task automatic cyc(input string tag, input logic [7:0] ex, ey, ea, esp, ep,
                     input logic eph2);
    item_t it;
    @(posedge clk);
    #1;
    it.tag = tag;
    it.exp = {ex, ey, ea, esp, ep, ~eph2, eph2};
    q.push_back(it);
  endtask

  task automatic clr();
    bus.x_con = 0; bus.y_con = 0; bus.accumulator_con = 0;
    bus.stack_pointer_con = 0; bus.status_con = 0;
`ifdef MOS_REGS_SP_STEP_EN
    bus.sp_inc = 0; bus.sp_dec = 0;
`endif
  endtask

  initial begin
    int guard;
    clr();
    bus.data_in = 8'h00;
    bus.data_status = 8'h00;

    // Reset, with a load strobe present to show reset wins.
    rst = 0; bus.x_con = 1; bus.data_in = 8'hEE;
    cyc("rst0", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 0);
    cyc("rst1", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 0);
    clr();
    rst = 1;
    cyc("rel_phi2", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 1);
    cyc("rel_phi1", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 0);

    // Phase gating: strobe during phi1 ignored, across phi2 edge taken.
    bus.x_con = 1; bus.data_in = 8'h5A;
    cyc("x_in_phi1", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 1);
    cyc("x_in_phi2", 8'h5A, 8'h00, 8'h00, 8'hFF, 8'h24, 0);
    clr();

    // All five loads in one edge; P bit 5 forced.
    bus.x_con = 1; bus.y_con = 1; bus.accumulator_con = 1;
    bus.stack_pointer_con = 1; bus.status_con = 1;
    bus.data_in = 8'hC3; bus.data_status = 8'h81;
    cyc("all_phi1", 8'h5A, 8'h00, 8'h00, 8'hFF, 8'h24, 1);
    cyc("all_load", 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hA1, 0);
    clr();

    // P bit 5 reads 1 after writing zero.
    bus.status_con = 1; bus.data_status = 8'h00;
    cyc("p_phi1", 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'hA1, 1);
    cyc("p_bit5", 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h20, 0);
    clr();

    // Load A, then reset on a phi2 edge with a competing load.
    bus.accumulator_con = 1; bus.data_in = 8'h7F;
    cyc("a_phi1", 8'hC3, 8'hC3, 8'hC3, 8'hC3, 8'h20, 1);
    cyc("a_load", 8'hC3, 8'hC3, 8'h7F, 8'hC3, 8'h20, 0);
    bus.data_in = 8'h11;
    cyc("a_hold", 8'hC3, 8'hC3, 8'h7F, 8'hC3, 8'h20, 1);
    rst = 0;
    cyc("mid_rst", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 0);
    rst = 1; clr();
    cyc("post_rst", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 1);

`ifdef MOS_REGS_SP_STEP_EN
    // SP stepping with wraps, cancel and load priority.
    bus.sp_inc = 1;
    cyc("inc_wrap", 8'h00, 8'h00, 8'h00, 8'h00, 8'h24, 0);
    bus.sp_inc = 0; bus.sp_dec = 1;
    cyc("dec_phi1", 8'h00, 8'h00, 8'h00, 8'h00, 8'h24, 1);
    cyc("dec_wrap", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 0);
    bus.sp_inc = 1;
    cyc("incdec_phi1", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 1);
    cyc("inc_dec", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 0);
    bus.sp_inc = 0; bus.stack_pointer_con = 1; bus.data_in = 8'h40;
    cyc("prio_phi1", 8'h00, 8'h00, 8'h00, 8'hFF, 8'h24, 1);
    cyc("con_prio", 8'h00, 8'h00, 8'h00, 8'h40, 8'h24, 0);
    clr();
`else
    // SP load after reset, checked on the next write edge.
    bus.stack_pointer_con = 1; bus.data_in = 8'h40;
    cyc("sp_load", 8'h00, 8'h00, 8'h00, 8'h40, 8'h24, 0);
    clr();
`endif
    cyc("idle", 8'h00, 8'h00, 8'h00, 8'h40, 8'h24, 1);

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d snapshots left, want 0", q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
